// File: rtl/rc4_var_key_if.sv
// Key-load, byte-stream and status bundle of rc4_var_key; master = source/sink side, slave = cipher core.
// key_stream exists only when RC4_KS_OUT_EN is defined.
interface rc4_var_key_if;
  logic [7:0] key_input;
  logic       key_valid;
  logic       key_last;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_ready;
  logic       key_stream_valid;
  logic       key_err;
`ifdef RC4_KS_OUT_EN
  logic [7:0] key_stream;
`endif

  modport master (
    output key_input, key_valid, key_last, din, din_valid,
`ifdef RC4_KS_OUT_EN
    input  key_stream,
`endif
    input  dout, dout_ready, key_stream_valid, key_err
  );

  modport slave (
    input  key_input, key_valid, key_last, din, din_valid,
`ifdef RC4_KS_OUT_EN
    output key_stream,
`endif
    output dout, dout_ready, key_stream_valid, key_err
  );
endinterface

// File: rtl/rc4_var_key.sv
// RC4 / RC4-drop[DROP_N] cipher with 1..KEY_MAX byte runtime key; RC4_KS_OUT_EN adds a key_stream debug port.
// dout 1 cycle after din_valid, 1 byte/cycle in READY; no backpressure, din outside READY or under key_valid is dropped.
module rc4_var_key #(
  parameter int KEY_MAX = 16,
  parameter int DROP_N  = 0
) (
  input  logic         clk,
  input  logic         rst,
  rc4_var_key_if.slave bus
);
  localparam int          KW        = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam logic [8:0]  KEY_FULL  = 9'(KEY_MAX);
  localparam logic [11:0] DROP_LAST = 12'((DROP_N > 0) ? DROP_N - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, INIT, KSA, DROP, READY} state_t;

  state_t        state;
  logic [7:0]    sbox    [256];
  logic [7:0]    key_mem [2**KW];
  logic [7:0]    i, j;
  logic [8:0]    key_len;
  logic [KW-1:0] kidx;
  logic [11:0]   drop_cnt;
  logic          key_done;
  logic [7:0]    dout_q;
  logic          dout_ready_q, ksv_q, key_err_q;
`ifdef RC4_KS_OUT_EN
  logic [7:0]    ks_q;
`endif

  logic [7:0] ksa_j, ip, si, jp, sj, t, ks;
  logic       key_start, init_step, ksa_step, prga_step, key_store;

  // ks reads post-swap S[t] without waiting for the swap to land
  always_comb begin
    ksa_j = j + sbox[i] + key_mem[kidx];
    ip    = i + 8'd1;
    si    = sbox[ip];
    jp    = j + si;
    sj    = sbox[jp];
    t     = si + sj;
    if (t == ip)
      ks = sj;
    else if (t == jp)
      ks = si;
    else
      ks = sbox[t];
  end

  assign key_start = bus.key_valid && (state != LOAD || key_done);
  assign key_store = bus.key_valid && state == LOAD && !key_done && key_len != KEY_FULL;
  assign init_step = !bus.key_valid && state == INIT;
  assign ksa_step  = !bus.key_valid && state == KSA;
  assign prga_step = !bus.key_valid && (state == DROP || (state == READY && bus.din_valid));

  always_ff @(posedge clk) begin
    if (init_step) begin
      sbox[i] <= i;
    end else if (ksa_step) begin
      sbox[i]     <= sbox[ksa_j];
      sbox[ksa_j] <= sbox[i];
    end else if (prga_step) begin
      sbox[ip] <= sj;
      sbox[jp] <= si;
    end
  end

  always_ff @(posedge clk) begin
    if (key_start)
      key_mem[0] <= bus.key_input;
    else if (key_store)
      key_mem[key_len[KW-1:0]] <= bus.key_input;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      i            <= 8'd0;
      j            <= 8'd0;
      key_len      <= 9'd0;
      kidx         <= '0;
      drop_cnt     <= 12'd0;
      key_done     <= 1'b0;
      dout_q       <= 8'd0;
      dout_ready_q <= 1'b0;
      ksv_q        <= 1'b0;
      key_err_q    <= 1'b0;
`ifdef RC4_KS_OUT_EN
      ks_q         <= 8'd0;
`endif
    end else begin
      dout_ready_q <= 1'b0;
      if (key_start) begin
        state     <= LOAD;
        key_len   <= 9'd1;
        key_done  <= bus.key_last;
        key_err_q <= 1'b0;
        ksv_q     <= 1'b0;
        i         <= 8'd0;
        j         <= 8'd0;
      end else begin
        case (state)
          // key_done costs one extra LOAD cycle before INIT starts
          LOAD: begin
            if (key_done) begin
              state <= INIT;
              i     <= 8'd0;
            end else if (bus.key_valid) begin
              if (key_len == KEY_FULL)
                key_err_q <= 1'b1;
              else
                key_len <= key_len + 9'd1;
              key_done <= bus.key_last;
            end
          end
          INIT: begin
            i <= i + 8'd1;
            if (i == 8'hff) begin
              state <= KSA;
              j     <= 8'd0;
              kidx  <= '0;
            end
          end
          KSA: begin
            i    <= i + 8'd1;
            j    <= ksa_j;
            kidx <= ({{(9-KW){1'b0}}, kidx} == key_len - 9'd1) ? '0 : kidx + KW'(1);
            if (i == 8'hff) begin
              j <= 8'd0;
              if (DROP_N == 0) begin
                state <= READY;
                ksv_q <= 1'b1;
              end else begin
                state    <= DROP;
                drop_cnt <= 12'd0;
              end
            end
          end
          DROP: begin
            i        <= ip;
            j        <= jp;
            drop_cnt <= drop_cnt + 12'd1;
`ifdef RC4_KS_OUT_EN
            ks_q     <= ks;
`endif
            if (drop_cnt == DROP_LAST) begin
              state <= READY;
              ksv_q <= 1'b1;
            end
          end
          READY: begin
            if (bus.din_valid) begin
              i            <= ip;
              j            <= jp;
              dout_q       <= bus.din ^ ks;
              dout_ready_q <= 1'b1;
`ifdef RC4_KS_OUT_EN
              ks_q         <= ks;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.dout             = dout_q;
  assign bus.dout_ready       = dout_ready_q;
  assign bus.key_stream_valid = ksv_q;
  assign bus.key_err          = key_err_q;
`ifdef RC4_KS_OUT_EN
  assign bus.key_stream       = ks_q;
`endif
endmodule

// File: tb/tb_rc4_var_key.sv
// Scoreboard bench for rc4_var_key: DROP_N=0 and DROP_N=3 instances checked against a behavioural RC4 model.
module tb_rc4_var_key;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc4_var_key_if bus0();
  rc4_var_key_if bus3();

  rc4_var_key #(.KEY_MAX(16), .DROP_N(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rc4_var_key #(.KEY_MAX(16), .DROP_N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q0[$];
  logic [7:0] q3[$];
  logic [7:0] exp0, exp3, last0;
  logic [7:0] key_buf [256];
  logic [7:0] pt_buf  [16];
  logic [7:0] ct_buf  [16];
  logic [7:0] m_s [256];
  logic [7:0] m_i, m_j;

  localparam logic [127:0] KEY1 = 128'hcc28bec716a9d4ad4d677f36c051f8f6;
  localparam logic [127:0] PT1  = 128'h1b565f6bce1bde2f9e5363c7;
  localparam logic [127:0] CT1  = 128'h090cd8c0ac12f5eb6d7b38de;
  localparam logic [127:0] KEY2 = 128'h0a1caebce6db3327122618832fc53f3d;
  localparam logic [127:0] PT2  = 128'h4c91f0e5a68cd7c643148267;
  localparam logic [127:0] CT2  = 128'h1039d7326a7ed17cd80da9a3;

  task automatic set_key(input logic [255:0] v, input int n);
    for (int b = 0; b < n; b++) key_buf[b] = v[8*(n-1-b) +: 8];
  endtask

  task automatic set_pt(input logic [127:0] p, input logic [127:0] c, input int n);
    for (int b = 0; b < n; b++) begin
      pt_buf[b] = p[8*(n-1-b) +: 8];
      ct_buf[b] = c[8*(n-1-b) +: 8];
    end
  endtask

  task automatic model_init(input int len);
    logic [7:0] tmp;
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
    m_j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      m_j = m_j + m_s[n] + key_buf[n % len];
      tmp = m_s[n]; m_s[n] = m_s[m_j]; m_s[m_j] = tmp;
    end
    m_i = 8'd0;
    m_j = 8'd0;
  endtask

  function automatic logic [7:0] model_ks();
    logic [7:0] tmp;
    m_i = m_i + 8'd1;
    m_j = m_j + m_s[m_i];
    tmp = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = tmp;
    tmp = m_s[m_i] + m_s[m_j];
    return m_s[tmp];
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && bus0.dout_ready === 1'b1) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL dout0_unexpected: dout_ready=1 dout=%h, no output expected", bus0.dout);
      end else begin
        exp0 = q0.pop_front();
        if (bus0.dout !== exp0) begin
          n_fail++;
          $display("FAIL dout0_data: got %h expected %h", bus0.dout, exp0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && bus3.dout_ready === 1'b1) begin
      n_checks++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL dout3_unexpected: dout_ready=1 dout=%h, no output expected", bus3.dout);
      end else begin
        exp3 = q3.pop_front();
        if (bus3.dout !== exp3) begin
          n_fail++;
          $display("FAIL dout3_data: got %h expected %h", bus3.dout, exp3);
        end
      end
    end
  end

  task automatic load_key0(input int n, input bit wait_rdy, input bit din_too);
    int cyc;
    @(negedge clk);
    bus0.key_valid = 1'b1;
    bus0.key_input = key_buf[0];
    bus0.key_last  = (n == 1);
    bus0.din       = 8'h5a;
    bus0.din_valid = din_too;
    @(negedge clk);
    bus0.key_valid = 1'b0;
    bus0.key_last  = 1'b0;
    bus0.din_valid = 1'b0;
    n_checks++;
    if (bus0.key_stream_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL key_load_ksv_low: key_stream_valid=%b expected 0", bus0.key_stream_valid);
    end
    n_checks++;
    if (bus0.key_err !== 1'b0) begin
      n_fail++;
      $display("FAIL key_load_err_clear: key_err=%b expected 0", bus0.key_err);
    end
    for (int b = 1; b < n; b++) begin
      @(negedge clk);
      bus0.key_valid = 1'b1;
      bus0.key_input = key_buf[b];
      bus0.key_last  = (b == n - 1);
    end
    if (n > 1) begin
      @(negedge clk);
      bus0.key_valid = 1'b0;
      bus0.key_last  = 1'b0;
    end
    if (wait_rdy) begin
      cyc = 0;
      while (cyc < 2000 && bus0.key_stream_valid !== 1'b1) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      n_checks++;
      if (cyc != 513) begin
        n_fail++;
        $display("FAIL ksv_latency: rose after %0d cycles expected 513", cyc);
      end
      @(negedge clk);
    end
  endtask

  task automatic encrypt0(input int n, input int gap_after, input int gap_len, input bit use_ct);
    logic [7:0] ks;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      bus0.din       = pt_buf[b];
      bus0.din_valid = 1'b1;
      ks = model_ks();
      last0 = use_ct ? ct_buf[b] : (pt_buf[b] ^ ks);
      q0.push_back(last0);
      if (b == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          bus0.din_valid = 1'b0;
          bus0.din       = 8'hff;
          if (g > 0) begin
            n_checks++;
            if (bus0.dout_ready !== 1'b0) begin
              n_fail++;
              $display("FAIL gap_dout_ready: dout_ready=%b expected 0", bus0.dout_ready);
            end
          end
        end
      end
    end
    @(negedge clk);
    bus0.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d bytes outstanding expected 0", q0.size());
    end
    n_checks++;
    if (bus0.dout !== last0) begin
      n_fail++;
      $display("FAIL dout_hold: dout=%h expected %h", bus0.dout, last0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if (bus0.dout !== 8'h00 || bus0.dout_ready !== 1'b0 ||
        bus0.key_stream_valid !== 1'b0 || bus0.key_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: dout=%h rdy=%b ksv=%b err=%b expected all 0",
               bus0.dout, bus0.dout_ready, bus0.key_stream_valid, bus0.key_err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus0.din       = 8'h33;
      bus0.din_valid = 1'b1;
    end
    @(negedge clk);
    bus0.din_valid = 1'b0;
    n_checks++;
    if (bus0.dout_ready !== 1'b0 || bus0.key_stream_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL unkeyed_din: dout_ready=%b ksv=%b expected 0 0", bus0.dout_ready, bus0.key_stream_valid);
    end
  endtask

  task automatic test_case1();
    set_key(256'(KEY1), 16);
    set_pt(PT1, CT1, 12);
    model_init(16);
    load_key0(16, 1'b1, 1'b0);
    encrypt0(12, -1, 0, 1'b0);
  endtask

  task automatic test_gap_rekey();
    set_key(256'(KEY1), 16);
    set_pt(PT1, CT1, 12);
    model_init(16);
    load_key0(16, 1'b1, 1'b0);
    encrypt0(12, 5, 2, 1'b0);
    set_key(256'(KEY2), 16);
    set_pt(PT2, CT2, 12);
    model_init(16);
    load_key0(16, 1'b1, 1'b1);
    encrypt0(12, -1, 0, 1'b0);
  endtask

  task automatic test_short_key();
    set_key(256'h4b6579, 3);
    set_pt(128'h506c61696e74657874, 128'hbbf316e8d940af0ad3, 9);
    model_init(3);
    load_key0(3, 1'b1, 1'b0);
    encrypt0(9, -1, 0, 1'b1);
  endtask

  task automatic test_overflow();
    set_key(256'(KEY1), 16);
    key_buf[16] = 8'hee;
    set_pt(PT1, CT1, 12);
    model_init(16);
    load_key0(17, 1'b1, 1'b0);
    n_checks++;
    if (bus0.key_err !== 1'b1) begin
      n_fail++;
      $display("FAIL key_err_overflow: key_err=%b expected 1", bus0.key_err);
    end
    encrypt0(12, -1, 0, 1'b0);
    n_checks++;
    if (bus0.key_err !== 1'b1) begin
      n_fail++;
      $display("FAIL key_err_sticky: key_err=%b expected 1", bus0.key_err);
    end
  endtask

  task automatic test_reset_mid_ksa();
    set_key(256'(KEY1), 16);
    key_buf[16] = 8'h11;
    load_key0(17, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus0.dout !== 8'h00 || bus0.dout_ready !== 1'b0 ||
        bus0.key_stream_valid !== 1'b0 || bus0.key_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: dout=%h rdy=%b ksv=%b err=%b expected all 0",
               bus0.dout, bus0.dout_ready, bus0.key_stream_valid, bus0.key_err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus0.din       = 8'h77;
      bus0.din_valid = 1'b1;
      if (c > 0) begin
        n_checks++;
        if (bus0.dout_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL unkeyed_after_reset: dout_ready=%b expected 0", bus0.dout_ready);
        end
      end
    end
    @(negedge clk);
    bus0.din_valid = 1'b0;
    set_key(256'(KEY1), 16);
    set_pt(PT1, CT1, 12);
    model_init(16);
    load_key0(16, 1'b1, 1'b0);
    encrypt0(12, -1, 0, 1'b0);
  endtask

  task automatic test_drop();
    logic [7:0] pre [3];
    int cyc;
    set_key(256'(KEY1), 16);
    set_pt(PT1, CT1, 12);
    model_init(16);
    for (int k = 0; k < 3; k++) pre[k] = model_ks();
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      bus3.key_valid = 1'b1;
      bus3.key_input = key_buf[b];
      bus3.key_last  = (b == 15);
    end
    @(negedge clk);
    bus3.key_valid = 1'b0;
    bus3.key_last  = 1'b0;
    bus3.din       = 8'h99;
    bus3.din_valid = 1'b1;
    cyc = 0;
    while (cyc < 2000 && bus3.key_stream_valid !== 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
`ifdef RC4_KS_OUT_EN
      if (cyc >= 514 && cyc <= 516) begin
        n_checks++;
        if (bus3.key_stream !== pre[cyc-514]) begin
          n_fail++;
          $display("FAIL drop_key_stream: byte %0d got %h expected %h", cyc - 514, bus3.key_stream, pre[cyc-514]);
        end
      end
`endif
    end
    n_checks++;
    if (cyc != 516) begin
      n_fail++;
      $display("FAIL drop_ksv_latency: rose after %0d cycles expected 516", cyc);
    end
    for (int b = 0; b < 12; b++) begin
      @(negedge clk);
      bus3.din       = pt_buf[b];
      bus3.din_valid = 1'b1;
      q3.push_back(pt_buf[b] ^ model_ks());
    end
    @(negedge clk);
    bus3.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (q3.size() != 0) begin
      n_fail++;
      $display("FAIL drop_scoreboard_drain: %0d bytes outstanding expected 0", q3.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus0.key_input = 8'h00; bus0.key_valid = 1'b0; bus0.key_last = 1'b0;
    bus0.din       = 8'h00; bus0.din_valid = 1'b0;
    bus3.key_input = 8'h00; bus3.key_valid = 1'b0; bus3.key_last = 1'b0;
    bus3.din       = 8'h00; bus3.din_valid = 1'b0;
    test_reset();
    test_case1();
    test_gap_rekey();
    test_short_key();
    test_overflow();
    test_reset_mid_ksa();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
